// File: rtl/float_sp_pkg.sv
// float_sp_pkg: shared definitions for the float byte serializer.
//   lp_FLOAT_SP_ZERO   canonical +0.0 substituted for flagged words
//   lp_BYTES_PER_WORD  data bytes per frame
//   ser_state_t        serializer FSM states (ST_CHK only with FLOAT_SER_CHECKSUM_EN)
//   byte_select()      picks byte <idx> of a word in MSB- or LSB-first order
// Optional feature macro: FLOAT_SER_CHECKSUM_EN
package float_sp_pkg;

   localparam logic [31:0] lp_FLOAT_SP_ZERO  = 32'h0000_0000;
   localparam int unsigned lp_BYTES_PER_WORD = 4;
   localparam logic [1:0]  lp_LAST_IDX       = 2'(lp_BYTES_PER_WORD - 1);

`ifdef FLOAT_SER_CHECKSUM_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_CHK = 2'd2} ser_state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1} ser_state_t;
`endif

   // idx counts bytes in transmission order; lane is the physical byte position.
   function automatic logic [7:0] byte_select(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic        msb_first);
      logic [1:0] lane;
      lane = msb_first ? (2'd3 - idx) : idx;
      return word[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/float_ser_fifo.sv
// float_ser_fifo: synchronous word FIFO, registered write, combinational read of
// the head entry, no same-cycle bypass (a pushed word is visible the cycle after).
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   push, din        write request/data (ignored when full)
//   pop, dout        read request/head data (ignored when empty)
//   full, empty      occupancy status
//   count            number of stored words (0..p_DEPTH)
module float_ser_fifo #(
   parameter int unsigned p_DEPTH = 4,
   parameter int unsigned p_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [p_WIDTH-1:0]       din,
   input  logic                     pop,
   output logic [p_WIDTH-1:0]       dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(p_DEPTH):0] count
);

   localparam int unsigned AW       = $clog2(p_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(p_DEPTH);

   logic [p_WIDTH-1:0] mem [p_DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

endmodule

// File: rtl/float_sp_byte_serializer.sv
// float_sp_byte_serializer: buffers converted float words (flagged words become
// +0.0) and streams each as a byte frame over a valid/ready interface.
// Ports:
//   i_CLK, i_RESET             clock, synchronous active-high reset
//   i_VALID, i_FLOAT_WORD,
//   i_INVALID                  push-only word input from the converter
//   o_READY                    FIFO not full (status only)
//   o_OVERFLOW                 sticky: a word was dropped on a full FIFO
//   o_BYTE, o_BYTE_VALID,
//   i_BYTE_READY, o_LAST       byte stream; o_LAST marks the final frame byte
// Optional feature macro: FLOAT_SER_CHECKSUM_EN (appends XOR checksum byte).
module float_sp_byte_serializer #(
   parameter int unsigned p_FIFO_DEPTH = 4,
   parameter bit          p_MSB_FIRST  = 1'b1
) (
   input  logic        i_CLK,
   input  logic        i_RESET,
   input  logic        i_VALID,
   input  logic [31:0] i_FLOAT_WORD,
   input  logic        i_INVALID,
   output logic        o_READY,
   output logic        o_OVERFLOW,
   output logic [7:0]  o_BYTE,
   output logic        o_BYTE_VALID,
   input  logic        i_BYTE_READY,
   output logic        o_LAST
);

   import float_sp_pkg::*;

   localparam int unsigned  CW       = $clog2(p_FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(p_FIFO_DEPTH);

   ser_state_t    state;
   ser_state_t    state_next;
   logic [31:0]   fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          push;
   logic          pop;
   logic [31:0]   word_reg;
   logic [1:0]    byte_idx;
   logic          overflow;

   // Full is judged on the registered count, so a pop in the same cycle
   // does not rescue a write that arrives while full.
   assign push = i_VALID && !fifo_full;
   assign pop  = (state == ST_IDLE) && !fifo_empty;

   float_ser_fifo #(
      .p_DEPTH (p_FIFO_DEPTH),
      .p_WIDTH (32)
   ) u_fifo (
      .clk   (i_CLK),
      .reset (i_RESET),
      .push  (push),
      .din   (i_INVALID ? lp_FLOAT_SP_ZERO : i_FLOAT_WORD),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifdef FLOAT_SER_CHECKSUM_EN
   logic [7:0] checksum;
   assign checksum = word_reg[31:24] ^ word_reg[23:16] ^ word_reg[15:8] ^ word_reg[7:0];
`endif

   always_ff @(posedge i_CLK) begin
      if (i_RESET) state <= ST_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (!fifo_empty) state_next = ST_SEND;
         ST_SEND: begin
            if (i_BYTE_READY && (byte_idx == lp_LAST_IDX)) begin
`ifdef FLOAT_SER_CHECKSUM_EN
               state_next = ST_CHK;
`else
               state_next = ST_IDLE;
`endif
            end
         end
`ifdef FLOAT_SER_CHECKSUM_EN
         ST_CHK:  if (i_BYTE_READY) state_next = ST_IDLE;
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         word_reg <= '0;
         byte_idx <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop) begin
            word_reg <= fifo_dout;
            byte_idx <= '0;
         end else if ((state == ST_SEND) && i_BYTE_READY) begin
            byte_idx <= byte_idx + 2'd1;
         end
         if (i_VALID && fifo_full) overflow <= 1'b1;
      end
   end

   always_comb begin
      o_BYTE       = '0;
      o_BYTE_VALID = 1'b0;
      o_LAST       = 1'b0;
      case (state)
         ST_SEND: begin
            o_BYTE_VALID = 1'b1;
            o_BYTE       = byte_select(word_reg, byte_idx, p_MSB_FIRST);
`ifndef FLOAT_SER_CHECKSUM_EN
            o_LAST       = (byte_idx == lp_LAST_IDX);
`endif
         end
`ifdef FLOAT_SER_CHECKSUM_EN
         ST_CHK: begin
            o_BYTE_VALID = 1'b1;
            o_BYTE       = checksum;
            o_LAST       = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign o_READY    = (fifo_count != FULL_CNT);
   assign o_OVERFLOW = overflow;

endmodule

// File: tb/tb_float_sp_byte_serializer.sv
// Testbench for float_sp_byte_serializer: queue-based reference model of the
// word FIFO and frame engine, directed scenarios plus randomized traffic.
module tb_float_sp_byte_serializer;

   localparam int unsigned DEPTH = 4;
   localparam bit          MSB   = 1'b1;
`ifdef FLOAT_SER_CHECKSUM_EN
   localparam int unsigned FRAME = 5;
`else
   localparam int unsigned FRAME = 4;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic [31:0] word;
   logic        inv;
   logic        ready;
   logic        overflow;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        last;

   always #5 clk = ~clk;

   float_sp_byte_serializer #(
      .p_FIFO_DEPTH (DEPTH),
      .p_MSB_FIRST  (MSB)
   ) dut (
      .i_CLK        (clk),
      .i_RESET      (reset),
      .i_VALID      (valid),
      .i_FLOAT_WORD (word),
      .i_INVALID    (inv),
      .o_READY      (ready),
      .o_OVERFLOW   (overflow),
      .o_BYTE       (byte_out),
      .o_BYTE_VALID (byte_valid),
      .i_BYTE_READY (byte_ready),
      .o_LAST       (last)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] m_q[$];
   logic [7:0]  m_frame[$];
   logic [7:0]  m_acc[$];
   logic        m_ovf   = 1'b0;
   logic        m_valid = 1'b0;
   logic [7:0]  m_byte  = 8'h00;
   logic        m_last  = 1'b0;
   logic        m_ready = 1'b1;

   // Bytes actually handed over by the DUT
   logic [7:0]  got_bytes[$];
   logic        got_last[$];

   function automatic void load_frame(input logic [31:0] w);
      logic [7:0] b;
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 4; i++) begin
         b = 8'((w >> (8 * (MSB ? (3 - i) : i))) & 32'hFF);
         m_frame.push_back(b);
         x = x ^ b;
      end
      if (FRAME == 5) m_frame.push_back(x);
   endfunction

   function automatic string dut_s();
      return $sformatf("v=%b b=%h l=%b r=%b ovf=%b", byte_valid, byte_out, last, ready, overflow);
   endfunction

   function automatic string mdl_s();
      return $sformatf("v=%b b=%h l=%b r=%b ovf=%b", m_valid, m_byte, m_last, m_ready, m_ovf);
   endfunction

   // One clock: drive inputs, advance DUT and model, land on the next negedge.
   task automatic tick(input logic v, input logic [31:0] w, input logic iv,
                       input logic rdy, input logic rst);
      bit was_full;
      bit had_word;
      valid = v; word = w; inv = iv; byte_ready = rdy; reset = rst;
      if (byte_valid && rdy && !rst) begin
         got_bytes.push_back(byte_out);
         got_last.push_back(last);
      end
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_frame.delete();
         m_ovf = 1'b0;
      end else begin
         was_full = (m_q.size() >= DEPTH);
         had_word = (m_q.size() > 0);
         if (m_frame.size() > 0) begin
            if (rdy) m_acc.push_back(m_frame.pop_front());
         end else if (had_word) begin
            load_frame(m_q.pop_front());
         end
         if (v) begin
            if (was_full) m_ovf = 1'b1;
            else          m_q.push_back(iv ? 32'h0 : w);
         end
      end
      m_valid = (m_frame.size() > 0);
      m_byte  = m_valid ? m_frame[0] : 8'h00;
      m_last  = (m_frame.size() == 1);
      m_ready = (m_q.size() < DEPTH);
      @(negedge clk);
   endtask

   task automatic clear_capture();
      got_bytes.delete();
      got_last.delete();
      m_acc.delete();
   endtask

   task automatic test_reset();
      tick(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
      tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if ({byte_valid, byte_out, last, ready, overflow} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_values: got %s, expected v=0 b=00 l=0 r=1 ovf=0", dut_s());
      end
      tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({byte_valid, byte_out, last, ready, overflow} !== {m_valid, m_byte, m_last, m_ready, m_ovf}) begin
         n_fail++;
         $display("FAIL reset_release: got %s, expected %s", dut_s(), mdl_s());
      end
   endtask

   task automatic test_single();
      logic [7:0] exp[5];
      bit         bad;
      if (MSB) begin
         exp[0] = 8'h3F; exp[1] = 8'h80; exp[2] = 8'h00; exp[3] = 8'h00;
      end else begin
         exp[0] = 8'h00; exp[1] = 8'h00; exp[2] = 8'h80; exp[3] = 8'h3F;
      end
      exp[4] = 8'hBF;
      clear_capture();
      tick(1'b1, 32'h3F80_0000, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (byte_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_latency_k: byte_valid=%b, expected 0", byte_valid);
      end
      tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({byte_valid, byte_out} !== {1'b1, exp[0]}) begin
         n_fail++;
         $display("FAIL single_latency_k1: got v=%b b=%h, expected v=1 b=%h", byte_valid, byte_out, exp[0]);
      end
      for (int c = 0; c < 8; c++) begin
         tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
         n_checks++;
         if ({byte_valid, byte_out, last, ready, overflow} !== {m_valid, m_byte, m_last, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL single_cycle%0d: got %s, expected %s", c, dut_s(), mdl_s());
         end
      end
      bad = (got_bytes.size() != FRAME);
      for (int i = 0; i < FRAME && !bad; i++)
         if (got_bytes[i] !== exp[i] || got_last[i] !== (i == FRAME - 1)) bad = 1'b1;
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL single_frame: got %p last %p, expected first %0d of %p", got_bytes, got_last, FRAME, exp);
      end
   endtask

   task automatic test_invalid();
      bit bad;
      clear_capture();
      tick(1'b1, 32'h4F00_0000, 1'b1, 1'b1, 1'b0);
      for (int c = 0; c < 9; c++) begin
         tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
         n_checks++;
         if ({byte_valid, byte_out, last, ready, overflow} !== {m_valid, m_byte, m_last, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL invalid_cycle%0d: got %s, expected %s", c, dut_s(), mdl_s());
         end
      end
      bad = (got_bytes.size() != FRAME);
      for (int i = 0; i < FRAME && !bad; i++)
         if (got_bytes[i] !== 8'h00) bad = 1'b1;
      n_checks++;
      if (bad || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL invalid_zero: got %p ovf=%b, expected %0d zero bytes ovf=0", got_bytes, overflow, FRAME);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp[5];
      logic [7:0] prev_byte;
      logic       prev_last;
      logic       prev_valid;
      logic       prev_rdy;
      logic       rdy;
      bit         bad;
      if (MSB) begin
         exp[0] = 8'hC2; exp[1] = 8'hF6; exp[2] = 8'h00; exp[3] = 8'h00;
      end else begin
         exp[0] = 8'h00; exp[1] = 8'h00; exp[2] = 8'hF6; exp[3] = 8'hC2;
      end
      exp[4] = 8'h34;
      clear_capture();
      tick(1'b1, 32'hC2F6_0000, 1'b0, 1'b1, 1'b0);
      prev_valid = 1'b0; prev_rdy = 1'b1; prev_byte = 8'h00; prev_last = 1'b0;
      for (int c = 0; c < 24; c++) begin
         rdy = ((c % 4) == 0) || ((c % 4) == 3);
         prev_valid = byte_valid; prev_byte = byte_out; prev_last = last; prev_rdy = rdy;
         tick(1'b0, 32'h0, 1'b0, rdy, 1'b0);
         n_checks++;
         if ({byte_valid, byte_out, last, ready, overflow} !== {m_valid, m_byte, m_last, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL bp_cycle%0d: got %s, expected %s", c, dut_s(), mdl_s());
         end
         if (prev_valid && !prev_rdy) begin
            n_checks++;
            if ({byte_valid, byte_out, last} !== {1'b1, prev_byte, prev_last}) begin
               n_fail++;
               $display("FAIL bp_hold%0d: got v=%b b=%h l=%b, expected v=1 b=%h l=%b",
                        c, byte_valid, byte_out, last, prev_byte, prev_last);
            end
         end
      end
      bad = (got_bytes.size() != FRAME);
      for (int i = 0; i < FRAME && !bad; i++)
         if (got_bytes[i] !== exp[i]) bad = 1'b1;
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL bp_order: got %p, expected first %0d of %p", got_bytes, FRAME, exp);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] w;
      bit          bad;
      clear_capture();
      // One word moves into the shift register, so six back-to-back pushes are
      // needed to overrun a depth-4 FIFO while the sink is stalled.
      for (int c = 0; c < 6; c++) begin
         w = $urandom;
         tick(1'b1, w, 1'b0, 1'b0, 1'b0);
         n_checks++;
         if ({byte_valid, byte_out, last, ready, overflow} !== {m_valid, m_byte, m_last, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL ovf_fill%0d: got %s, expected %s", c, dut_s(), mdl_s());
         end
      end
      n_checks++;
      if ({ready, overflow} !== 2'b01) begin
         n_fail++;
         $display("FAIL ovf_flags: got ready=%b ovf=%b, expected ready=0 ovf=1", ready, overflow);
      end
      for (int c = 0; c < 30; c++) begin
         tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
         n_checks++;
         if ({byte_valid, byte_out, last, ready, overflow} !== {m_valid, m_byte, m_last, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL ovf_drain%0d: got %s, expected %s", c, dut_s(), mdl_s());
         end
      end
      bad = (got_bytes.size() != 5 * FRAME) || (got_bytes.size() != m_acc.size());
      for (int i = 0; i < got_bytes.size() && !bad; i++)
         if (got_bytes[i] !== m_acc[i]) bad = 1'b1;
      n_checks++;
      if (bad || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_frames: got %0d bytes ovf=%b, expected %0d bytes ovf=1", got_bytes.size(), overflow, 5 * FRAME);
      end
   endtask

   task automatic test_reset_midframe();
      tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      clear_capture();
      tick(1'b1, 32'h1111_2222, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 32'h3333_4444, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 32'h5555_6666, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (got_bytes.size() != 2 || byte_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL midframe_setup: got %0d bytes v=%b, expected 2 bytes v=1", got_bytes.size(), byte_valid);
      end
      tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if ({byte_valid, byte_out, last, ready, overflow} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL midframe_reset: got %s, expected v=0 b=00 l=0 r=1 ovf=0", dut_s());
      end
      for (int c = 0; c < 15; c++) begin
         tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
         n_checks++;
         if ({byte_valid, byte_out, last, ready, overflow} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL midframe_quiet%0d: got %s, expected v=0 b=00 l=0 r=1 ovf=0", c, dut_s());
         end
      end
      n_checks++;
      if (got_bytes.size() != 2) begin
         n_fail++;
         $display("FAIL midframe_count: got %0d bytes, expected 2", got_bytes.size());
      end
   endtask

   task automatic test_random();
      bit bad;
      clear_capture();
      for (int c = 0; c < 400; c++) begin
         tick($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) != 0, 1'b0);
         n_checks++;
         if ({byte_valid, byte_out, last, ready, overflow} !== {m_valid, m_byte, m_last, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL rand_cycle%0d: got %s, expected %s", c, dut_s(), mdl_s());
         end
      end
      for (int c = 0; c < 40; c++) begin
         tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
         n_checks++;
         if ({byte_valid, byte_out, last, ready, overflow} !== {m_valid, m_byte, m_last, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL rand_drain%0d: got %s, expected %s", c, dut_s(), mdl_s());
         end
      end
      bad = (got_bytes.size() != m_acc.size()) || (m_frame.size() != 0) || (m_q.size() != 0);
      for (int i = 0; i < got_bytes.size() && !bad; i++)
         if (got_bytes[i] !== m_acc[i]) bad = 1'b1;
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL rand_stream: got %0d bytes, expected %0d bytes with matching content",
                  got_bytes.size(), m_acc.size());
      end
   endtask

   initial begin
      reset = 1'b1; valid = 1'b0; word = 32'h0; inv = 1'b0; byte_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_invalid();
      test_backpressure();
      test_overflow();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
